// File: rtl/cyclic74_decoder.sv
// cyclic74_decoder: serial-syndrome single-error-correcting decoder for the (7,4) cyclic code, g(x)=x^3+x+1
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid/in_ready     codeword input handshake, cw_in = {p2,p1,p0,u3,u2,u1,u0}
//   out_valid/out_ready   result handshake; data_out, cw_out, syndrome, err_flag held while out_valid
//   cnt_clr, err_cnt      synchronous clear / saturating count of corrected words
module cyclic74_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       cw_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       data_out,
    output logic [6:0]       cw_out,
    output logic [2:0]       syndrome,
    output logic             err_flag,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] err_cnt
);
    typedef enum logic [1:0] {IDLE, SHIFT, CORRECT, OUT} state_t;

    state_t     state, state_nxt;
    logic [6:0] cw;
    logic [6:0] r;
    logic [2:0] lfsr;
    logic [2:0] cnt;
    logic [6:0] flip;
    logic       bit_in;

    // r in polynomial order, so the bit fed at count c is r[6-c] (u3 first, p0 last)
    assign r         = {cw[3:0], cw[6:4]};
    assign bit_in    = r[3'd6 - cnt];
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == OUT);
    assign data_out  = cw_out[3:0];

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = in_valid ? SHIFT : IDLE;
            SHIFT:   state_nxt = (cnt == 3'd6) ? CORRECT : SHIFT;
            CORRECT: state_nxt = OUT;
            OUT:     state_nxt = out_ready ? IDLE : OUT;
            default: state_nxt = IDLE;
        endcase
    end

    // syndrome of x^k mod g(x) for each codeword bit position
    always_comb begin
        flip = 7'b0;
        case (lfsr)
            3'b001:  flip = 7'b0010000;
            3'b010:  flip = 7'b0100000;
            3'b100:  flip = 7'b1000000;
            3'b011:  flip = 7'b0000001;
            3'b110:  flip = 7'b0000010;
            3'b111:  flip = 7'b0000100;
            3'b101:  flip = 7'b0001000;
            default: flip = 7'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cw       <= '0;
            lfsr     <= '0;
            cnt      <= '0;
            cw_out   <= '0;
            syndrome <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    cw   <= cw_in;
                    lfsr <= '0;
                    cnt  <= '0;
                end
                SHIFT: begin
                    lfsr <= {lfsr[1], lfsr[0] ^ lfsr[2], bit_in ^ lfsr[2]};
                    cnt  <= (cnt == 3'd6) ? cnt : cnt + 3'd1;
                end
                CORRECT: begin
                    syndrome <= lfsr;
                    err_flag <= |lfsr;
                    cw_out   <= cw ^ flip;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        err_cnt <= '0;
        else if (cnt_clr)                                  err_cnt <= '0;
        else if (state == CORRECT && |lfsr && !(&err_cnt)) err_cnt <= err_cnt + CNT_W'(1);
    end
endmodule

// File: tb/tb_cyclic74_decoder.sv
// tb_cyclic74_decoder: table and scoreboard driven check of the (7,4) cyclic decoder
module tb_cyclic74_decoder;
    typedef struct {
        logic [6:0] cw;
        logic [3:0] data;
        logic [6:0] cw_exp;
        logic [2:0] syn;
        logic       err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [6:0]  cw_in = '0;
    logic        out_ready = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        in_ready, out_valid, err_flag;
    logic [3:0]  data_out;
    logic [6:0]  cw_out;
    logic [2:0]  syndrome;
    logic [15:0] err_cnt;
    logic        in_ready2, out_valid2, err_flag2;
    logic [3:0]  data_out2;
    logic [6:0]  cw_out2;
    logic [2:0]  syndrome2;
    logic [1:0]  err_cnt2;

    int   errors = 0;
    int   checks = 0;
    vec_t sb[$];
    vec_t tbl[8];
    logic [2:0] syn_pos[7];

    always #5 clk = ~clk;

    cyclic74_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .cw_in(cw_in),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out), .cw_out(cw_out),
        .syndrome(syndrome), .err_flag(err_flag), .cnt_clr(cnt_clr), .err_cnt(err_cnt)
    );

    cyclic74_decoder #(.CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .cw_in(cw_in),
        .out_valid(out_valid2), .out_ready(out_ready), .data_out(data_out2), .cw_out(cw_out2),
        .syndrome(syndrome2), .err_flag(err_flag2), .cnt_clr(cnt_clr), .err_cnt(err_cnt2)
    );

    function automatic logic [6:0] enc(input logic [3:0] u);
        logic p0, p1, p2;
        p0 = u[0] ^ u[2] ^ u[3];
        p1 = u[0] ^ u[1] ^ u[2];
        p2 = u[1] ^ u[2] ^ u[3];
        return {p2, p1, p0, u};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic accept(input vec_t v, input bit push);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_ready", in_ready, 1);
        cw_in = v.cw;
        in_valid = 1'b1;
        if (push) sb.push_back(v);
        @(negedge clk);
        in_valid = 1'b0;
        cw_in = 7'($urandom);
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (!out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("out_valid_timeout", out_valid, 1);
    endtask

    task automatic check_out();
        vec_t e;
        chk("sb_size", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("data_out", data_out, e.data);
            chk("cw_out", cw_out, e.cw_exp);
            chk("syndrome", syndrome, e.syn);
            chk("err_flag", err_flag, e.err);
            chk("data_out_w2", data_out2, e.data);
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("out_valid_drop", out_valid, 0);
        chk("in_ready_after", in_ready, 1);
    endtask

    task automatic send(input vec_t v, input bit check_lat);
        int n;
        accept(v, 1);
        wait_out(n);
        if (check_lat) chk("latency", n, 9);
        check_out();
        handshake();
    endtask

    initial begin
        int   n;
        bit   stable;
        logic [14:0] saved;
        vec_t v;
        logic [6:0] c;

        syn_pos = '{3'b011, 3'b110, 3'b111, 3'b101, 3'b001, 3'b010, 3'b100};
        tbl[0] = '{7'b0001011, 4'b1011, 7'b0001011, 3'b000, 1'b0};
        tbl[1] = '{7'b0110000, 4'b0001, 7'b0110001, 3'b011, 1'b1};
        tbl[2] = '{7'b0110011, 4'b0001, 7'b0110001, 3'b110, 1'b1};
        tbl[3] = '{7'b0110101, 4'b0001, 7'b0110001, 3'b111, 1'b1};
        tbl[4] = '{7'b0111001, 4'b0001, 7'b0110001, 3'b101, 1'b1};
        tbl[5] = '{7'b0100001, 4'b0001, 7'b0110001, 3'b001, 1'b1};
        tbl[6] = '{7'b0010001, 4'b0001, 7'b0110001, 3'b010, 1'b1};
        tbl[7] = '{7'b1110001, 4'b0001, 7'b0110001, 3'b100, 1'b1};

        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_cw_out", cw_out, 0);
        chk("rst_syndrome", syndrome, 0);
        chk("rst_err_flag", err_flag, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        #1 chk("in_ready_release", in_ready, 1);
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send(tbl[i], 1'b1);
            if (i == 0) chk("err_cnt_clean", err_cnt, 0);
        end
        chk("err_cnt_sweep", err_cnt, 7);

        accept(tbl[0], 1);
        wait_out(n);
        saved = {data_out, cw_out, syndrome, err_flag};
        stable = 1'b1;
        in_valid = 1'b1;
        cw_in = 7'b1111111;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!out_valid || in_ready || {data_out, cw_out, syndrome, err_flag} != saved) stable = 1'b0;
        end
        in_valid = 1'b0;
        chk("bp_stable", stable, 1);
        check_out();
        handshake();
        send('{7'b1001011, 4'b1011, 7'b0001011, 3'b100, 1'b1}, 1'b1);
        chk("err_cnt_bp", err_cnt, 8);

        accept(tbl[3], 0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        stable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) stable = 1'b0;
        end
        chk("midrst_no_output", stable, 1);
        send('{7'b0001111, 4'b1011, 7'b0001011, 3'b111, 1'b1}, 1'b1);
        chk("err_cnt_post_rst", err_cnt, 1);

        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("cnt_clr", err_cnt, 0);
        chk("cnt_clr_w2", err_cnt2, 0);
        for (int i = 1; i <= 5; i++) send(tbl[i], 1'b1);
        chk("err_cnt_five", err_cnt, 5);
        chk("err_cnt_sat", err_cnt2, 3);
        accept(tbl[7], 1);
        repeat (7) @(negedge clk);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr_wins", err_cnt, 0);
        chk("clr_wins_w2", err_cnt2, 0);
        wait_out(n);
        check_out();
        handshake();

        for (int m = 0; m < 16; m++) begin
            c = enc(4'(m));
            v = '{c, 4'(m), c, 3'b000, 1'b0};
            send(v, 1'b0);
            for (int b = 0; b < 7; b++) begin
                v.cw = c ^ (7'b1 << b);
                v.syn = syn_pos[b];
                v.err = 1'b1;
                send(v, 1'b0);
            end
        end
        chk("err_cnt_exh", err_cnt, 112);
        chk("err_cnt_exh_w2", err_cnt2, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
